// File: rtl/me_sad_engine_if.sv
// Bus bundle for me_sad_engine: pixel write ports, search control and result.
interface me_sad_engine_if #(
  parameter int BLK = 16,
  parameter int WIN = 32,
  parameter int PPW = 8
);
  localparam int MAX_R = (WIN - BLK) / 2;
  localparam int MVW   = $clog2(MAX_R) + 2;
  localparam int SADW  = $clog2(BLK * BLK * 255 + 1);
  localparam int CAW   = $clog2(BLK * BLK / PPW);
  localparam int RAW   = $clog2(WIN * WIN / PPW);

  logic [1:0]         r;
  logic               go;
  logic [CAW-1:0]     address_write_cur;
  logic [8*PPW-1:0]   data_write_cur;
  logic               write_enable_cur;
  logic [RAW-1:0]     address_write_ref;
  logic [8*PPW-1:0]   data_write_ref;
  logic               write_enable_ref;
  logic               busy;
  logic               done;
  logic [MVW-1:0]     best_mvx;
  logic [MVW-1:0]     best_mvy;
  logic [SADW-1:0]    best_sad;
  logic               wr_err;

  modport master (
    output r, go, address_write_cur, data_write_cur, write_enable_cur,
           address_write_ref, data_write_ref, write_enable_ref,
    input  busy, done, best_mvx, best_mvy, best_sad, wr_err
  );

  modport slave (
    input  r, go, address_write_cur, data_write_cur, write_enable_cur,
           address_write_ref, data_write_ref, write_enable_ref,
    output busy, done, best_mvx, best_mvy, best_sad, wr_err
  );
endinterface

// File: rtl/me_sad_engine.sv
// Full-search SAD motion estimation. One block row per cycle is reduced to a
// row SAD (BLK absolute-difference lanes + adder tree), registered, then
// accumulated and compared against the running best in a second stage.
module me_sad_engine #(
  parameter int BLK = 16,
  parameter int WIN = 32,
  parameter int PPW = 8
) (
  input logic           clk,
  input logic           reset,
  me_sad_engine_if.slave bus
);
  localparam int MAX_R = (WIN - BLK) / 2;
  localparam int MVW   = $clog2(MAX_R) + 2;
  localparam int SADW  = $clog2(BLK * BLK * 255 + 1);
  localparam int RSW   = $clog2(BLK * 255 + 1);
  localparam int RW    = $clog2(BLK);
  localparam int WAW   = $clog2(WIN);
  localparam int CWPR  = BLK / PPW;
  localparam int RWPR  = WIN / PPW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;

  logic [7:0] cur_mem [BLK][BLK];
  logic [7:0] ref_mem [WIN][WIN];

  // write address decode: word -> (row, first column)
  logic [RW-1:0]  cw_row, cw_col;
  logic [WAW-1:0] rw_row, rw_col;
  always_comb begin
    cw_row = RW'(int'(bus.address_write_cur) / CWPR);
    cw_col = RW'((int'(bus.address_write_cur) % CWPR) * PPW);
    rw_row = WAW'(int'(bus.address_write_ref) / RWPR);
    rw_col = WAW'((int'(bus.address_write_ref) % RWPR) * PPW);
  end

  // pixel storage; not reset, writes blocked while a search is running
  always_ff @(posedge clk) begin
    if (state != RUN && bus.write_enable_cur)
      for (int k = 0; k < PPW; k++)
        cur_mem[cw_row][cw_col + RW'(k)] <= bus.data_write_cur[8*k +: 8];
    if (state != RUN && bus.write_enable_ref)
      for (int k = 0; k < PPW; k++)
        ref_mem[rw_row][rw_col + WAW'(k)] <= bus.data_write_ref[8*k +: 8];
  end

  // search counters and stage-1 registers
  logic [RW-1:0]          row;
  logic signed [MVW-1:0]  dx, dy, rad;
  logic                   issuing;
  logic                   s1_vld, s1_last, s1_fin;
  logic [RSW-1:0]         s1_rs;
  logic signed [MVW-1:0]  s1_dx, s1_dy;
  logic [SADW-1:0]        acc, best_int;
  logic signed [MVW-1:0]  bmx, bmy;
  logic                   go_q;

  logic                   busy_q, done_q, wr_err_q;
  logic [MVW-1:0]         mvx_q, mvy_q;
  logic [SADW-1:0]        sad_q;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.best_mvx = mvx_q;
  assign bus.best_mvy = mvy_q;
  assign bus.best_sad = sad_q;

  // radius select, clamped to what the window allows
  int                    r_pow;
  logic signed [MVW-1:0] r_sel;
  always_comb begin
    r_pow = 2 << bus.r;
    r_sel = (r_pow > MAX_R) ? MVW'(MAX_R) : MVW'(r_pow);
  end

  logic go_acc;
  assign go_acc = bus.go && !go_q && (state != RUN);

  // reference window origin for the current row/candidate
  logic [WAW-1:0] ry, rx;
  always_comb begin
    ry = WAW'(MAX_R + int'(dy) + int'(row));
    rx = WAW'(MAX_R + int'(dx));
  end

  // per-pixel absolute-difference lanes
  logic [BLK-1:0][7:0] absd;
  for (genvar j = 0; j < BLK; j++) begin : g_lane
    logic [7:0] a, b;
    assign a       = cur_mem[row][j];
    assign b       = ref_mem[ry][rx + WAW'(j)];
    assign absd[j] = (a > b) ? a - b : b - a;
  end

  // row SAD reduction
  logic [RSW-1:0] rowsad;
  always_comb begin
    rowsad = '0;
    for (int k = 0; k < BLK; k++) rowsad = rowsad + RSW'(absd[k]);
  end

  logic last_row, last_cand;
  assign last_row  = (row == RW'(BLK - 1));
  assign last_cand = last_row && (dx == rad) && (dy == rad);

  // candidate total and strict best update (earliest candidate wins ties)
  logic [SADW-1:0]       total, nb_sad;
  logic signed [MVW-1:0] nb_mx, nb_my;
  logic                  upd;
  always_comb begin
    total  = acc + SADW'(s1_rs);
    upd    = total < best_int;
    nb_sad = upd ? total : best_int;
    nb_mx  = upd ? s1_dx : bmx;
    nb_my  = upd ? s1_dy : bmy;
  end

  // control FSM, scan counters, accumulator and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      mvx_q    <= '0;
      mvy_q    <= '0;
      sad_q    <= '0;
      rad      <= '0;
      dx       <= '0;
      dy       <= '0;
      row      <= '0;
      issuing  <= 1'b0;
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_fin   <= 1'b0;
      s1_rs    <= '0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      acc      <= '0;
      best_int <= '1;
      bmx      <= '0;
      bmy      <= '0;
    end else begin
      go_q <= bus.go;
      if (state == RUN && (bus.write_enable_cur || bus.write_enable_ref))
        wr_err_q <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (go_acc) begin
            state    <= RUN;
            rad      <= r_sel;
            dx       <= -r_sel;
            dy       <= -r_sel;
            row      <= '0;
            issuing  <= 1'b1;
            s1_vld   <= 1'b0;
            acc      <= '0;
            best_int <= '1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        RUN: begin
          s1_vld <= issuing;
          if (issuing) begin
            s1_rs   <= rowsad;
            s1_last <= last_row;
            s1_fin  <= last_cand;
            s1_dx   <= dx;
            s1_dy   <= dy;
            if (last_row) begin
              row <= '0;
              if (dx == rad) begin
                dx <= -rad;
                dy <= dy + 1'b1;
              end else begin
                dx <= dx + 1'b1;
              end
              if (last_cand) issuing <= 1'b0;
            end else begin
              row <= row + 1'b1;
            end
          end
          if (s1_vld) begin
            if (!s1_last) begin
              acc <= total;
            end else begin
              acc      <= '0;
              best_int <= nb_sad;
              bmx      <= nb_mx;
              bmy      <= nb_my;
              if (s1_fin) begin
                state  <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                sad_q  <= nb_sad;
                mvx_q  <= nb_mx;
                mvy_q  <= nb_my;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_me_sad_engine.sv
// Self-checking bench for me_sad_engine: directed scenarios plus random
// searches checked against a plain full-search reference model.
module tb_me_sad_engine;
  localparam int BLK   = 16;
  localparam int WIN   = 32;
  localparam int PPW   = 8;
  localparam int MAX_R = (WIN - BLK) / 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  me_sad_engine_if #(.BLK(BLK), .WIN(WIN), .PPW(PPW)) bus ();
  me_sad_engine #(.BLK(BLK), .WIN(WIN), .PPW(PPW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  byte unsigned cur_px [BLK*BLK];
  byte unsigned ref_px [WIN*WIN];

  // reference full search straight from the definition
  function automatic void model(input int rr, output int mx, output int my, output int sad);
    int R, s, d;
    R = 2 << rr;
    if (R > MAX_R) R = MAX_R;
    sad = 1 << 30; mx = 0; my = 0;
    for (int y = -R; y <= R; y++)
      for (int x = -R; x <= R; x++) begin
        s = 0;
        for (int i = 0; i < BLK; i++)
          for (int j = 0; j < BLK; j++) begin
            d = int'(cur_px[i*BLK+j]) - int'(ref_px[(MAX_R+y+i)*WIN + MAX_R+x+j]);
            s += (d < 0) ? -d : d;
          end
        if (s < sad) begin sad = s; mx = x; my = y; end
      end
  endfunction

  function automatic int lat(input int rr);
    int R;
    R = 2 << rr;
    if (R > MAX_R) R = MAX_R;
    return (2*R+1)*(2*R+1)*BLK + 1;
  endfunction

  task automatic load_mem();
    logic [8*PPW-1:0] w;
    for (int a = 0; a < WIN*WIN/PPW; a++) begin
      @(negedge clk);
      for (int k = 0; k < PPW; k++)
        w[8*k +: 8] = ref_px[(a/(WIN/PPW))*WIN + (a%(WIN/PPW))*PPW + k];
      bus.address_write_ref = a[6:0];
      bus.data_write_ref = w;
      bus.write_enable_ref = 1'b1;
      if (a < BLK*BLK/PPW) begin
        for (int k = 0; k < PPW; k++)
          w[8*k +: 8] = cur_px[(a/(BLK/PPW))*BLK + (a%(BLK/PPW))*PPW + k];
        bus.address_write_cur = a[4:0];
        bus.data_write_cur = w;
        bus.write_enable_cur = 1'b1;
      end else begin
        bus.write_enable_cur = 1'b0;
      end
    end
    @(negedge clk);
    bus.write_enable_ref = 1'b0;
    bus.write_enable_cur = 1'b0;
  endtask

  task automatic go_accept(input int rr);
    @(negedge clk);
    bus.r = rr[1:0];
    bus.go = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic go_low();
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (bus.done !== 1'b1 && edges < budget);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.wr_err, bus.best_mvx, bus.best_mvy, bus.best_sad} !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b wr_err=%b mvx=%0d mvy=%0d sad=%0d, want all 0",
               bus.busy, bus.done, bus.wr_err, bus.best_mvx, bus.best_mvy, bus.best_sad);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_exact_match();
    int e, gx, gy;
    foreach (ref_px[i]) ref_px[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < BLK; i++)
      for (int j = 0; j < BLK; j++)
        cur_px[i*BLK+j] = ref_px[(MAX_R-2+i)*WIN + MAX_R+3+j];
    load_mem();
    go_accept(1);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL exact_busy: busy=%b done=%b want 1/0", bus.busy, bus.done);
    end
    wait_done(2000, e);
    gx = $signed(bus.best_mvx); gy = $signed(bus.best_mvy);
    checks++;
    if (e !== 1297) begin errors++; $display("FAIL exact_latency: got %0d want 1297", e); end
    checks++;
    if (gx !== 3 || gy !== -2) begin errors++; $display("FAIL exact_mv: got (%0d,%0d) want (3,-2)", gx, gy); end
    checks++;
    if (bus.best_sad !== 0) begin errors++; $display("FAIL exact_sad: got %0d want 0", bus.best_sad); end
    go_low();
  endtask

  task automatic test_tie_width();
    int e, gx, gy;
    foreach (cur_px[i]) cur_px[i] = 8'h00;
    foreach (ref_px[i]) ref_px[i] = 8'hFF;
    load_mem();
    go_accept(0);
    wait_done(1000, e);
    gx = $signed(bus.best_mvx); gy = $signed(bus.best_mvy);
    checks++;
    if (e !== 401) begin errors++; $display("FAIL tie_latency: got %0d want 401", e); end
    checks++;
    if (gx !== -2 || gy !== -2) begin errors++; $display("FAIL tie_mv: got (%0d,%0d) want (-2,-2)", gx, gy); end
    checks++;
    if (bus.best_sad !== 65280) begin errors++; $display("FAIL tie_sad: got %0d want 65280", bus.best_sad); end
    go_low();
  endtask

  task automatic test_range_clamp();
    int e, gx, gy, mx, my, ms;
    foreach (ref_px[i]) ref_px[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < BLK; i++)
      for (int j = 0; j < BLK; j++)
        cur_px[i*BLK+j] = ref_px[(MAX_R+8+i)*WIN + MAX_R+8+j];
    load_mem();
    go_accept(3);
    wait_done(6000, e);
    gx = $signed(bus.best_mvx); gy = $signed(bus.best_mvy);
    checks++;
    if (e !== 4625) begin errors++; $display("FAIL clamp_latency: got %0d want 4625", e); end
    checks++;
    if (gx !== 8 || gy !== 8 || bus.best_sad !== 0) begin
      errors++; $display("FAIL clamp_r3: got (%0d,%0d) sad %0d want (8,8) sad 0", gx, gy, bus.best_sad);
    end
    go_low();
    model(0, mx, my, ms);
    go_accept(0);
    wait_done(1000, e);
    gx = $signed(bus.best_mvx); gy = $signed(bus.best_mvy);
    checks++;
    if (gx !== mx || gy !== my || int'(bus.best_sad) !== ms) begin
      errors++; $display("FAIL clamp_r0: got (%0d,%0d) sad %0d want (%0d,%0d) sad %0d", gx, gy, bus.best_sad, mx, my, ms);
    end
    checks++;
    if (bus.best_sad == 0 || gx < -2 || gx > 2 || gy < -2 || gy > 2) begin
      errors++; $display("FAIL clamp_r0_range: got (%0d,%0d) sad %0d want |mv|<=2 sad>0", gx, gy, bus.best_sad);
    end
    go_low();
  endtask

  task automatic test_write_during_run();
    int e, gx, gy, mx, my, ms;
    model(0, mx, my, ms);
    for (int pass = 0; pass < 2; pass++) begin
      go_accept(0);
      if (pass == 0) begin
        repeat (50) @(posedge clk);
        @(negedge clk);
        bus.address_write_ref = 7'd5;
        bus.data_write_ref = {$urandom, $urandom};
        bus.write_enable_ref = 1'b1;
        bus.address_write_cur = 5'd0;
        bus.data_write_cur = {$urandom, $urandom};
        bus.write_enable_cur = 1'b1;
        @(negedge clk);
        bus.write_enable_ref = 1'b0;
        bus.write_enable_cur = 1'b0;
        checks++;
        if (bus.wr_err !== 1'b1 || bus.busy !== 1'b1) begin
          errors++; $display("FAIL wr_err_set: wr_err=%b busy=%b want 1/1", bus.wr_err, bus.busy);
        end
      end
      wait_done(1000, e);
      gx = $signed(bus.best_mvx); gy = $signed(bus.best_mvy);
      checks++;
      if (bus.done !== 1'b1 || gx !== mx || gy !== my || int'(bus.best_sad) !== ms) begin
        errors++; $display("FAIL wr_run_result%0d: done=%b (%0d,%0d) sad %0d want (%0d,%0d) sad %0d",
                           pass, bus.done, gx, gy, bus.best_sad, mx, my, ms);
      end
      checks++;
      if (bus.wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_sticky%0d: got %b want 1", pass, bus.wr_err); end
      go_low();
    end
  endtask

  task automatic test_reset_mid_run();
    int e, gx, gy, mx, my, ms;
    go_accept(2);
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.wr_err, bus.best_mvx, bus.best_mvy, bus.best_sad} !== '0) begin
      errors++; $display("FAIL mid_reset: busy=%b done=%b wr_err=%b mvx=%0d mvy=%0d sad=%0d want all 0",
                         bus.busy, bus.done, bus.wr_err, bus.best_mvx, bus.best_mvy, bus.best_sad);
    end
    bus.go = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model(1, mx, my, ms);
    go_accept(1);
    wait_done(2000, e);
    gx = $signed(bus.best_mvx); gy = $signed(bus.best_mvy);
    checks++;
    if (e !== 1297 || gx !== mx || gy !== my || int'(bus.best_sad) !== ms) begin
      errors++; $display("FAIL post_reset_run: edges %0d (%0d,%0d) sad %0d want 1297 (%0d,%0d) sad %0d",
                         e, gx, gy, bus.best_sad, mx, my, ms);
    end
    go_low();
  endtask

  task automatic test_held_go();
    int e, mx, my, ms, bad;
    model(0, mx, my, ms);
    go_accept(0);
    wait_done(1000, e);
    checks++;
    if (e !== 401) begin errors++; $display("FAIL held_latency: got %0d want 401", e); end
    bad = 0;
    repeat (900) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL held_go_single: %0d cycles not idle-done, want 0", bad); end
    go_low();
    go_accept(0);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || int'(bus.best_sad) !== ms) begin
      errors++; $display("FAIL rego_accept: done=%b busy=%b sad %0d want 0/1 sad %0d", bus.done, bus.busy, bus.best_sad, ms);
    end
    wait_done(1000, e);
    checks++;
    if (e !== 401 || int'(bus.best_sad) !== ms) begin
      errors++; $display("FAIL rego_done: edges %0d sad %0d want 401 sad %0d", e, bus.best_sad, ms);
    end
    go_low();
  endtask

  task automatic test_random();
    int e, gx, gy, mx, my, ms, rr;
    for (int it = 0; it < 3; it++) begin
      foreach (cur_px[i]) cur_px[i] = 8'($urandom_range(0, 255));
      foreach (ref_px[i]) ref_px[i] = 8'($urandom_range(0, 255));
      rr = $urandom_range(0, 3);
      load_mem();
      model(rr, mx, my, ms);
      go_accept(rr);
      wait_done(6000, e);
      gx = $signed(bus.best_mvx); gy = $signed(bus.best_mvy);
      checks++;
      if (e !== lat(rr)) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, e, lat(rr)); end
      checks++;
      if (gx !== mx || gy !== my || int'(bus.best_sad) !== ms) begin
        errors++; $display("FAIL rand%0d_result: got (%0d,%0d) sad %0d want (%0d,%0d) sad %0d",
                           it, gx, gy, bus.best_sad, mx, my, ms);
      end
      go_low();
    end
  endtask

  initial begin
    bus.r = 2'd0;
    bus.go = 1'b0;
    bus.address_write_cur = '0;
    bus.data_write_cur = '0;
    bus.write_enable_cur = 1'b0;
    bus.address_write_ref = '0;
    bus.data_write_ref = '0;
    bus.write_enable_ref = 1'b0;
    test_reset();
    test_exact_match();
    test_tie_width();
    test_range_clamp();
    test_write_during_run();
    test_reset_mid_run();
    test_held_go();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
